// File: rtl/v1_pulse_gen.sv
// v1_pulse_gen: test-pulse synthesizer standing in for the preamp/ADC in
// front of v1_filter. Each pulse is a linear rise to a latched amplitude,
// then a geometric decay (acc -= acc >> DECAY_SHIFT), added to a live
// baseline and saturated to the sample width. Single-shot or periodic.
module v1_pulse_gen #(
  parameter int unsigned SIZE_ADC_DATA = 14,
  parameter int unsigned DECAY_SHIFT   = 4,
  parameter int unsigned RISE_LOG2     = 2,
  parameter int unsigned PERIOD_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     repeat_en,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic [SIZE_ADC_DATA-1:0] baseline,
  input  logic [PERIOD_W-1:0]      period,
  output logic                     busy,
  output logic                     pulse_start,
  output logic                     overrun,
  output logic [SIZE_ADC_DATA-1:0] adc_data
);

  localparam int unsigned ACC_W    = SIZE_ADC_DATA + DECAY_SHIFT;
  localparam int unsigned RISE_LEN = 1 << RISE_LOG2;
  localparam int unsigned RC_W     = (RISE_LOG2 > 0) ? RISE_LOG2 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RISE,
    S_DECAY,
    S_GAP
  } state_t;

  state_t                   state_q;
  logic [ACC_W-1:0]         acc_q;
  logic [SIZE_ADC_DATA-1:0] amp_l_q;
  logic [PERIOD_W-1:0]      per_l_q;
  logic [RC_W-1:0]          rise_cnt_q;
  logic [PERIOD_W-1:0]      per_cnt_q;
  logic                     gap_first_q;
  logic                     busy_q;
  logic                     pulse_start_q;
  logic                     overrun_q;
  logic [SIZE_ADC_DATA-1:0] adc_q;

  logic [SIZE_ADC_DATA-1:0] acc_int;
  logic [SIZE_ADC_DATA:0]   sum;
  logic [SIZE_ADC_DATA-1:0] adc_d;
  logic [ACC_W-1:0]         amp_full;
  logic [ACC_W-1:0]         rise_step;
  logic [ACC_W-1:0]         decay_dec;
  logic                     rise_last;
  logic [PERIOD_W-1:0]      per_last;
  logic [PERIOD_W-1:0]      per_cnt_d;
  logic                     launch;

  // Datapath helpers: saturated output sample, rise/decay steps, period compare.
  always_comb begin
    acc_int   = acc_q[ACC_W-1 -: SIZE_ADC_DATA];
    sum       = {1'b0, baseline} + {1'b0, acc_int};
    adc_d     = sum[SIZE_ADC_DATA] ? '1 : sum[SIZE_ADC_DATA-1:0];
    amp_full  = ACC_W'(amp_l_q) << DECAY_SHIFT;
    rise_step = amp_full >> RISE_LOG2;
    decay_dec = acc_q >> DECAY_SHIFT;
    rise_last = (rise_cnt_q == RC_W'(RISE_LEN - 1));
    // A latched period of 0 behaves as 1.
    per_last  = (per_l_q == '0) ? '0 : per_l_q - 1'b1;
    per_cnt_d = (&per_cnt_q) ? per_cnt_q : per_cnt_q + 1'b1;
    // Start is honoured only in IDLE; GAP retriggers directly into RISE.
    launch    = ((state_q == S_IDLE) && start) ||
                ((state_q == S_GAP) && repeat_en && (per_cnt_q >= per_last));
  end

  // Pulse FSM with accumulator, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      amp_l_q       <= '0;
      per_l_q       <= '0;
      rise_cnt_q    <= '0;
      per_cnt_q     <= '0;
      gap_first_q   <= 1'b0;
      busy_q        <= 1'b0;
      pulse_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      adc_q         <= '0;
    end else begin
      adc_q         <= adc_d;
      pulse_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          acc_q <= '0;
        end
        S_RISE: begin
          per_cnt_q  <= per_cnt_d;
          rise_cnt_q <= rise_cnt_q + 1'b1;
          // Land exactly on the peak so step truncation never loses height.
          if (rise_last) begin
            acc_q   <= amp_full;
            state_q <= S_DECAY;
          end else begin
            acc_q <= acc_q + rise_step;
          end
        end
        S_DECAY: begin
          per_cnt_q <= per_cnt_d;
          if (decay_dec == '0) begin
            acc_q       <= '0;
            state_q     <= S_GAP;
            gap_first_q <= 1'b1;
          end else begin
            acc_q <= acc_q - decay_dec;
          end
        end
        S_GAP: begin
          per_cnt_q   <= per_cnt_d;
          gap_first_q <= 1'b0;
          if (!repeat_en) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (launch && gap_first_q) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // A new pulse overrides the per-state updates above.
      if (launch) begin
        amp_l_q       <= amplitude;
        per_l_q       <= period;
        rise_cnt_q    <= '0;
        per_cnt_q     <= '0;
        acc_q         <= '0;
        state_q       <= S_RISE;
        busy_q        <= 1'b1;
        pulse_start_q <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign pulse_start = pulse_start_q;
  assign overrun     = overrun_q;
  assign adc_data    = adc_q;

endmodule
